// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM, free-running cycle counter and a byte TX FIFO behind MMIO.
// Optional: define DMEM_TX_IRQ_EN to add the tx_irq pulse raised when the FIFO drains empty.
module data_mem_mmio #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef DMEM_TX_IRQ_EN
  ,
  output logic        tx_irq
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic          in_ram;
  logic          in_mmio;
  logic          sel_txdata;
  logic          sel_status;
  logic          sel_cycle;
  logic [AW-1:0] ram_idx;
  logic          addr_unused;

  assign in_ram      = (addr[31:12] == 20'h00000);
  assign in_mmio     = (addr[31:12] == 20'h00001);
  assign sel_txdata  = in_mmio && (addr[11:2] == 10'd0);
  assign sel_status  = in_mmio && (addr[11:2] == 10'd1);
  assign sel_cycle   = in_mmio && (addr[11:2] == 10'd2);
  assign ram_idx     = addr[AW+1:2];
  assign addr_unused = ^addr[1:0];

  logic [31:0] mem_q [MEM_WORDS];

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we && in_ram) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          pop;
  logic          push_req;
  logic          push_ok;

  assign tx_valid = (count_q != '0);
  assign tx_data  = fifo_q[rd_ptr_q];

  // A push into a full FIFO still lands when the head is leaving on the same edge.
  always_comb begin
    pop      = tx_valid && tx_ready;
    push_req = we && sel_txdata;
    push_ok  = push_req && ((count_q != FULL_COUNT) || pop);

    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q;
    if (we && sel_status) begin
      overflow_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end

    cycle_d = (we && sel_cycle) ? wdata : cycle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
    end
  end

  logic [2:0] count3;

  always_comb begin
    count3 = '0;
    for (int i = 0; i < 3 && i < CW; i++) begin
      count3[i] = count_q[i];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (in_ram) begin
      rdata = mem_q[ram_idx];
    end else if (sel_status) begin
      rdata = {23'd0, overflow_q, 3'd0, count3, (count_q == '0), (count_q == FULL_COUNT)};
    end else if (sel_cycle) begin
      rdata = cycle_q;
    end
  end

`ifdef DMEM_TX_IRQ_EN
  logic tx_irq_q, tx_irq_d;

  // Only a pop that empties the FIFO without a refilling push counts as drained.
  always_comb begin
    tx_irq_d = pop && !push_ok && (count_q == CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_q <= 1'b0;
    end else begin
      tx_irq_q <= tx_irq_d;
    end
  end

  assign tx_irq = tx_irq_q;
`endif

endmodule
